// File: rtl/toy_bus_pkg.sv
// Shared ToyBusReq field widths and the packed request payload record.
package toy_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int STRB_W = 32;
    localparam int DATA_W = 256;
    localparam int ID_W   = 4;
    localparam int SB_W   = 10;
    localparam int PLD_W  = ADDR_W + STRB_W + DATA_W + 1 + 2 * ID_W + SB_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
        logic              opcode;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
        logic [SB_W-1:0]   sideband;
    } toy_bus_req_pld_t;

endpackage

// File: rtl/toy_bus_rr_arb2.sv
// Two-input round-robin arbiter with a grant lock that pins the winner while
// the downstream side stalls.
module toy_bus_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       stall,
    output logic       sel,
    output logic       gnt_vld
);

    logic prio;
    logic lock;
    logic lock_id;

    // A locked grant outranks both prio and any newly raised request.
    always_comb begin
        sel = 1'b0;
        if (lock)
            sel = lock_id;
        else if (req[0] && req[1])
            sel = prio;
        else
            sel = req[1];
        gnt_vld = req[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
        end else if (accept) begin
            prio <= ~sel;
            lock <= 1'b0;
        end else if (stall) begin
            lock    <= 1'b1;
            lock_id <= sel;
        end
    end

endmodule

// File: rtl/toy_bus_arb_node_rr_pld_type_toybusreq.sv
// 2:1 round-robin merge node for ToyBusReq channels.
// TOY_BUS_ARB_NODE_OUT_REG_EN adds a 1-entry output register slice.
module toy_bus_arb_node_rr_pld_type_toybusreq
    import toy_bus_pkg::*;
#(
    parameter int ADDR_W = toy_bus_pkg::ADDR_W,
    parameter int STRB_W = toy_bus_pkg::STRB_W,
    parameter int DATA_W = toy_bus_pkg::DATA_W,
    parameter int ID_W   = toy_bus_pkg::ID_W,
    parameter int SB_W   = toy_bus_pkg::SB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic [ADDR_W-1:0] in0_addr,
    input  logic [STRB_W-1:0] in0_strb,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_opcode,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,
    input  logic [SB_W-1:0]   in0_sideband,
    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic [ADDR_W-1:0] in1_addr,
    input  logic [STRB_W-1:0] in1_strb,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_opcode,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,
    input  logic [SB_W-1:0]   in1_sideband,
    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic [ADDR_W-1:0] out0_addr,
    output logic [STRB_W-1:0] out0_strb,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_opcode,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id,
    output logic [SB_W-1:0]   out0_sideband
);

    toy_bus_req_pld_t pld0, pld1, pld_sel, pld_out;
    logic sel, gnt_vld, accept, stall, sel_rdy, vld_out;

    assign pld0 = '{addr: in0_addr, strb: in0_strb, data: in0_data, opcode: in0_opcode,
                    src_id: in0_src_id, tgt_id: in0_tgt_id, sideband: in0_sideband};
    assign pld1 = '{addr: in1_addr, strb: in1_strb, data: in1_data, opcode: in1_opcode,
                    src_id: in1_src_id, tgt_id: in1_tgt_id, sideband: in1_sideband};
    // With no requester sel falls to 0, so the idle payload is in0's.
    assign pld_sel = sel ? pld1 : pld0;

    toy_bus_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({in1_vld, in0_vld}),
        .accept  (accept),
        .stall   (stall),
        .sel     (sel),
        .gnt_vld (gnt_vld)
    );

`ifdef TOY_BUS_ARB_NODE_OUT_REG_EN
    logic             buf_vld;
    toy_bus_req_pld_t buf_pld;
    logic             can_load;

    // Arbitration happens at load time, so the lock is never needed here.
    assign can_load = !buf_vld || out0_rdy;
    assign accept   = gnt_vld && can_load;
    assign stall    = 1'b0;
    assign sel_rdy  = can_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            buf_vld <= 1'b0;
        else if (accept)
            buf_vld <= 1'b1;
        else if (out0_rdy)
            buf_vld <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept)
            buf_pld <= pld_sel;
    end

    assign vld_out = buf_vld;
    assign pld_out = buf_pld;
`else
    assign accept  = gnt_vld && out0_rdy;
    assign stall   = gnt_vld && !out0_rdy;
    assign sel_rdy = out0_rdy;
    assign vld_out = gnt_vld;
    assign pld_out = pld_sel;
`endif

    // Gate handshake outputs with rst_n so they drop the instant reset asserts.
    assign out0_vld = vld_out && rst_n;
    assign in0_rdy  = rst_n && sel_rdy && !sel;
    assign in1_rdy  = rst_n && sel_rdy && sel;

    assign out0_addr     = pld_out.addr;
    assign out0_strb     = pld_out.strb;
    assign out0_data     = pld_out.data;
    assign out0_opcode   = pld_out.opcode;
    assign out0_src_id   = pld_out.src_id;
    assign out0_tgt_id   = pld_out.tgt_id;
    assign out0_sideband = pld_out.sideband;

endmodule

// File: tb/tb_toy_bus_arb_node_rr_pld_type_toybusreq.sv
// Self-checking bench for the 2:1 ToyBusReq round-robin merge node.
module tb_toy_bus_arb_node_rr_pld_type_toybusreq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in0_vld = 1'b0, in1_vld = 1'b0, out0_rdy = 1'b0;
    logic in0_rdy, in1_rdy, out0_vld;
    logic [31:0] in0_addr = '0, in1_addr = '0, out0_addr;
    logic [31:0] in0_strb = '0, in1_strb = '0, out0_strb;
    logic [255:0] in0_data = '0, in1_data = '0, out0_data;
    logic in0_opcode = 1'b0, in1_opcode = 1'b0, out0_opcode;
    logic [3:0] in0_src_id = '0, in1_src_id = '0, out0_src_id;
    logic [3:0] in0_tgt_id = '0, in1_tgt_id = '0, out0_tgt_id;
    logic [9:0] in0_sideband = '0, in1_sideband = '0, out0_sideband;

    always #5 clk = ~clk;

    toy_bus_arb_node_rr_pld_type_toybusreq dut (
        .clk(clk), .rst_n(rst_n),
        .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_addr(in0_addr), .in0_strb(in0_strb),
        .in0_data(in0_data), .in0_opcode(in0_opcode), .in0_src_id(in0_src_id),
        .in0_tgt_id(in0_tgt_id), .in0_sideband(in0_sideband),
        .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_addr(in1_addr), .in1_strb(in1_strb),
        .in1_data(in1_data), .in1_opcode(in1_opcode), .in1_src_id(in1_src_id),
        .in1_tgt_id(in1_tgt_id), .in1_sideband(in1_sideband),
        .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_addr(out0_addr), .out0_strb(out0_strb),
        .out0_data(out0_data), .out0_opcode(out0_opcode), .out0_src_id(out0_src_id),
        .out0_tgt_id(out0_tgt_id), .out0_sideband(out0_sideband)
    );

    int checks = 0;
    int errors = 0;
    int cnt0 = 0, cnt1 = 0, xfers = 0;
    bit st0 = 0, st1 = 0, sb_en = 0, exp_next = 0;
    logic [31:0] q0[$], q1[$];
    logic s_vld, s_r0, s_r1;
    logic [3:0] s_src;
    logic [31:0] s_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input bit i, input int c);
        return (i ? 32'h100 : 32'h0) + 32'(c * 4);
    endfunction

    task automatic drive_pld(input bit i);
        logic [31:0] a;
        a = addr_of(i, i ? cnt1 : cnt0);
        if (!i) begin
            in0_addr = a; in0_strb = ~a; in0_data = {8{a}}; in0_opcode = a[2];
            in0_src_id = 4'd0; in0_tgt_id = 4'd0; in0_sideband = a[9:0] ^ 10'h155;
            q0.push_back(a);
        end else begin
            in1_addr = a; in1_strb = ~a; in1_data = {8{a}}; in1_opcode = a[2];
            in1_src_id = 4'd1; in1_tgt_id = 4'd3; in1_sideband = a[9:0] ^ 10'h155;
            q1.push_back(a);
        end
    endtask

    task automatic present(input bit i, input bit stream);
        drive_pld(i);
        if (!i) begin in0_vld = 1'b1; st0 = stream; end
        else    begin in1_vld = 1'b1; st1 = stream; end
    endtask

    // One clock: sample/score at negedge, advance the sources just after posedge.
    task automatic cyc();
        logic hs0, hs1, hso;
        logic [31:0] e;
        @(negedge clk);
        s_vld = out0_vld; s_r0 = in0_rdy; s_r1 = in1_rdy; s_src = out0_src_id; s_addr = out0_addr;
        hs0 = in0_vld && in0_rdy;
        hs1 = in1_vld && in1_rdy;
        hso = out0_vld && out0_rdy;
        if (sb_en && hso) begin
            xfers++;
            chk("sb_src", 64'(out0_src_id), 64'(exp_next));
            if ((exp_next ? q1.size() : q0.size()) == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                e = exp_next ? q1.pop_front() : q0.pop_front();
                chk("sb_addr", 64'(out0_addr), 64'(e));
                chk("sb_pld", {out0_data[63:0]}, {e, e});
                chk("sb_side", {out0_strb, out0_opcode, out0_tgt_id, out0_sideband},
                    {~e, e[2], (exp_next ? 4'd3 : 4'd0), e[9:0] ^ 10'h155});
            end
            exp_next = ~exp_next;
        end
        @(posedge clk);
        #1;
        if (hs0) begin
            if (st0) begin cnt0++; drive_pld(1'b0); end else in0_vld = 1'b0;
        end
        if (hs1) begin
            if (st1) begin cnt1++; drive_pld(1'b1); end else in1_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in0_vld = 1'b1; in1_vld = 1'b1; out0_rdy = 1'b1;
        #1;
        chk("rst_out", {61'd0, out0_vld, in0_rdy, in1_rdy}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        in0_vld = 1'b0; in1_vld = 1'b0; out0_rdy = 1'b0;
        st0 = 0; st1 = 0; cnt0 = 0; cnt1 = 0; xfers = 0; exp_next = 0;
        q0.delete(); q1.delete();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v0, v1, rdy;
        logic ev, er0, er1;
        logic esrc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{0, 0, 1, 0, 1, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 1, 1};
        tbl[2]  = '{1, 1, 1, 1, 1, 0, 0};
        tbl[3]  = '{1, 1, 1, 1, 0, 1, 1};
        tbl[4]  = '{1, 1, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 1, 1, 1, 1, 0, 0};
        tbl[6]  = '{1, 0, 1, 1, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1, 1, 1, 1, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[11] = '{1, 1, 0, 1, 0, 0, 0};
        tbl[12] = '{1, 1, 1, 1, 1, 0, 0};

        do_reset();

`ifndef TOY_BUS_ARB_NODE_OUT_REG_EN
        // Combinational vectors walking prio and lock through their states.
        drive_pld(1'b0); drive_pld(1'b1);
        for (int i = 0; i < 13; i++) begin
            in0_vld = tbl[i].v0; in1_vld = tbl[i].v1; out0_rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), {61'd0, out0_vld, in0_rdy, in1_rdy},
                {61'd0, tbl[i].ev, tbl[i].er0, tbl[i].er1});
            chk($sformatf("vec%0d_pld", i), {out0_addr, 24'd0, out0_src_id, out0_tgt_id},
                {(tbl[i].esrc ? 32'h100 : 32'h0), 24'd0, 3'd0, tbl[i].esrc,
                 (tbl[i].esrc ? 4'd3 : 4'd0)});
            @(posedge clk);
            #1;
        end
        do_reset();

        // in0 granted and stalled; in1 arriving mid-stall must not preempt.
        sb_en = 1;
        present(1'b0, 1'b0);
        out0_rdy = 1'b0;
        cyc();
        chk("stall_c1", {s_vld, s_r0, s_r1, s_src, s_addr}, {1'b1, 1'b0, 1'b0, 4'd0, 32'h0});
        present(1'b1, 1'b0);
        for (int c = 2; c <= 3; c++) begin
            cyc();
            chk($sformatf("stall_c%0d", c), {s_vld, s_r0, s_r1, s_src, s_addr},
                {1'b1, 1'b0, 1'b0, 4'd0, 32'h0});
        end
        out0_rdy = 1'b1;
        cyc();
        chk("stall_hs0", {s_r0, s_r1, s_src}, {1'b1, 1'b0, 4'd0});
        cyc();
        chk("stall_hs1", {s_r0, s_r1, s_src, s_addr}, {1'b0, 1'b1, 4'd1, 32'h100});
        chk("stall_xfers", 64'(xfers), 64'd2);
        sb_en = 0;
        do_reset();
`endif

        // Both inputs streaming: strict alternation, then ready toggling.
        sb_en = 1;
        present(1'b0, 1'b1); present(1'b1, 1'b1);
        out0_rdy = 1'b1;
        repeat (6) cyc();
`ifdef TOY_BUS_ARB_NODE_OUT_REG_EN
        chk("stream_xfers", 64'(xfers), 64'd5);
        out0_rdy = 1'b0;
        cyc();
        cyc();
        chk("hold_ctl", {s_vld, s_r0, s_r1}, {1'b1, 1'b0, 1'b0});
        out0_rdy = 1'b1;
        cyc();
`else
        chk("stream_xfers", 64'(xfers), 64'd6);
`endif
        for (int c = 0; c < 8; c++) begin
            out0_rdy = c[0] ? 1'b0 : 1'b1;
            cyc();
        end
        out0_rdy = 1'b1;
        st0 = 0; st1 = 0;
        repeat (4) cyc();
        chk("drain_q", 64'(q0.size() + q1.size()), 64'd0);
        chk("stream_cnt", 64'(xfers), 64'(cnt0 + cnt1 + 2));
        sb_en = 0;
        do_reset();

        // Reset asserted while in1 is stalled under lock.
        present(1'b0, 1'b1); present(1'b1, 1'b1);
        out0_rdy = 1'b1;
        cyc();
        out0_rdy = 1'b0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {61'd0, out0_vld, in0_rdy, in1_rdy}, 64'd0);
        do_reset();
        sb_en = 1;
        present(1'b0, 1'b1); present(1'b1, 1'b1);
        out0_rdy = 1'b1;
        cyc();
`ifndef TOY_BUS_ARB_NODE_OUT_REG_EN
        chk("midrst_first", {s_vld, s_r0, s_r1, s_src}, {1'b1, 1'b1, 1'b0, 4'd0});
`endif
        repeat (3) cyc();
        chk("midrst_xfers", 64'(xfers > 0), 64'd1);
        sb_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
